pwm_ramp_sequencer: RTL and testbench
=====================================

Name: pwm_ramp_sequencer

Overview:
Controller that sequences a soft-start / soft-stop duty profile for the PWM core. On a start request it ramps duty from 0 up to a target in fixed steps, holds for a programmed number of ticks, then ramps back to 0 and signals completion. It sits between the board-level control logic and the PWM datapath, and drives that datapath's duty input with a write strobe.

Parameters:
PWM_BITS, 10, width of duty, target and step.
TICK_DIV, 50_000, clk cycles per ramp tick (1 kHz at 50 MHz); must be >= 2.
HOLD_W, 16, width of the hold-tick count.

Ports:
clk  input  1  system clock (50 MHz).
rst  input  1  synchronous reset, active-high.
start  input  1  request a profile run; sampled only in IDLE.
abort  input  1  early soft stop: jump to ramp-down from the current duty.
target  input  PWM_BITS  peak duty.
step  input  PWM_BITS  duty increment/decrement per tick; 0 is treated as 1.
hold_ticks  input  HOLD_W  number of ticks spent at peak.
duty  output  PWM_BITS  registered duty to the PWM core.
duty_wr  output  1  one-cycle strobe; high in the first cycle a new duty value is visible.
busy  output  1  high from UP entry through the last DOWN cycle.
done  output  1  one-cycle completion pulse.
state_o  output  3  current state encoding, for debug.

Behaviour:
- Reset (synchronous, any state): duty=0, duty_wr=0, busy=0, done=0, state=IDLE, tick and hold counters=0. Takes effect at the next edge. Reset mid-run drops duty to 0 with no ramp-down.
- Tick generator: counter runs only when state is not IDLE. It is cleared on IDLE->UP. "tick" is asserted when the counter equals TICK_DIV-1, then the counter wraps to 0. The first tick after UP entry is at cycle TICK_DIV-1.
- IDLE: on start=1 and abort=0, latch target, step (0->1) and hold_ticks into shadow registers. At the next cycle, state=UP and busy=1. Input changes while not IDLE are ignored. If start and abort are both 1 in IDLE, there is no start.
- UP: on tick, compute sum = duty + step in PWM_BITS+1 bits.
  - If sum >= target: duty<=target. If shadow hold != 0, go to HOLD and load the hold counter; otherwise go straight to DOWN.
  - Otherwise duty<=sum.
  - target=0: the first tick leaves UP with duty unchanged.
- HOLD: on tick, decrement the hold counter. When the counter is 1 at a tick, go to DOWN. HOLD therefore lasts exactly hold_ticks ticks.
- DOWN: on tick, if duty <= step then duty<=0 and go to DONE; otherwise duty<=duty-step.
- DONE: lasts one cycle. done=1 and busy=0, then IDLE. A start seen in the DONE cycle is ignored.
- abort: in UP or HOLD, abort has priority over tick and moves the state to DOWN at the next edge with duty unchanged. The tick counter is not cleared. abort has no effect in DOWN, DONE or IDLE.
- duty_wr: pulses only when the duty register value actually changes. Writing an equal value produces no pulse.
- No arithmetic overflow is possible: comparisons use PWM_BITS+1 bits, and duty never exceeds target or goes below 0.

Decomposition:
- Shared package/header pwm_seq_pkg holds:
  - State encoding: IDLE=0, UP=1, HOLD=2, DOWN=3, DONE=4.
  - Default TICK_DIV, PWM_BITS and HOLD_W constants.
- One sub-module, ramp_tick_gen, with params TICK_DIV; ports clk, rst, en and tick. It is the divider counter and is reusable by other ramp blocks.
- The FSM and duty datapath stay in pwm_ramp_sequencer.

Test Plan:
- Full run: TICK_DIV=4, target=10, step=4, hold=2, start pulse. Required response:
  - busy rises at cycle T.
  - duty sequence 4, 8, 10, (hold two ticks), 6, 2, 0, with duty_wr high exactly 6 times.
  - done pulses at T+32 and busy is low at T+32.
- Zero hold and zero step: target=3, step=0, hold=0. Required response: duty 1, 2, 3, then 2, 1, 0; no HOLD state appears in state_o; done at T+24.
- Abort mid-ramp: same as the full run, with abort asserted in the cycle after duty=8. Required response: next state DOWN; duty goes 4, 0 on subsequent ticks; done pulses; duty never reaches 10.
- Reset mid-HOLD: rst=1 for one cycle while duty=10. Required response: the next cycle has duty=0, busy=0, done=0, state_o=0, and no done pulse follows.
- Start ignored while busy: pulse start with target=100 during UP. Required response: the profile still peaks at the latched target of 10; a start in the DONE cycle is ignored; a start in the following IDLE cycle begins a new run.
- target=0: required response: duty stays 0, no duty_wr pulse, HOLD entered for hold_ticks ticks, done pulses.

Source files
------------

// File: rtl/pwm_seq_pkg.sv
// Shared definitions for the PWM soft-start / soft-stop ramp sequencer.
package pwm_seq_pkg;

  localparam int PWM_BITS_DEF = 10;
  localparam int TICK_DIV_DEF = 50_000;
  localparam int HOLD_W_DEF   = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_UP   = 3'd1,
    ST_HOLD = 3'd2,
    ST_DOWN = 3'd3,
    ST_DONE = 3'd4
  } seq_state_t;

endpackage

// File: rtl/ramp_tick_gen.sv
// Ramp tick divider: one-cycle tick every TICK_DIV enabled clocks.
// The count is held at zero while disabled, so a fresh enable always
// produces its first tick TICK_DIV-1 cycles later.
module ramp_tick_gen
  import pwm_seq_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == TC);

  // Divider count: cleared by reset or disable, wraps after the terminal count.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt <= '0;
    end else if (cnt == TC) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Soft-start / soft-stop duty profile sequencer driving the PWM core.
//
//   state | meaning
//   IDLE  | waiting for start; duty is 0
//   UP    | ramping duty toward the latched target, one step per tick
//   HOLD  | sitting at peak for the latched number of ticks
//   DOWN  | ramping duty toward 0, one step per tick
//   DONE  | single-cycle completion pulse, then back to IDLE
module pwm_ramp_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF,
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int HOLD_W   = HOLD_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [PWM_BITS-1:0] target,
  input  logic [PWM_BITS-1:0] step,
  input  logic [HOLD_W-1:0]   hold_ticks,
  output logic [PWM_BITS-1:0] duty,
  output logic                duty_wr,
  output logic                busy,
  output logic                done,
  output logic [2:0]          state_o
);

  seq_state_t          state;
  logic                tick;
  logic [PWM_BITS-1:0] tgt_q;
  logic [PWM_BITS-1:0] step_q;
  logic [HOLD_W-1:0]   hold_q;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [PWM_BITS-1:0] step_eff;
  logic [PWM_BITS:0]   sum_up;
  logic                reach_tgt;
  logic                last_down;

  ramp_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (state != ST_IDLE),
    .tick(tick)
  );

  // A zero step would stall the ramp forever, so it is promoted to 1.
  assign step_eff  = (step == '0) ? PWM_BITS'(1) : step;
  assign sum_up    = {1'b0, duty} + {1'b0, step_q};
  assign reach_tgt = sum_up >= {1'b0, tgt_q};
  assign last_down = duty <= step_q;
  assign state_o   = state;

  // Sequencer FSM with duty datapath and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      duty     <= '0;
      duty_wr  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      tgt_q    <= '0;
      step_q   <= '0;
      hold_q   <= '0;
      hold_cnt <= '0;
    end else begin
      duty_wr <= 1'b0;
      done    <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            tgt_q  <= target;
            step_q <= step_eff;
            hold_q <= hold_ticks;
            busy   <= 1'b1;
            state  <= ST_UP;
          end
        end
        ST_UP: begin
          if (abort) begin
            state <= ST_DOWN;
          end else if (tick) begin
            if (reach_tgt) begin
              duty    <= tgt_q;
              duty_wr <= (duty != tgt_q);
              if (hold_q != '0) begin
                hold_cnt <= hold_q;
                state    <= ST_HOLD;
              end else begin
                state <= ST_DOWN;
              end
            end else begin
              duty    <= sum_up[PWM_BITS-1:0];
              duty_wr <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (abort) begin
            state <= ST_DOWN;
          end else if (tick) begin
            hold_cnt <= hold_cnt - 1'b1;
            if (hold_cnt == HOLD_W'(1)) begin
              state <= ST_DOWN;
            end
          end
        end
        ST_DOWN: begin
          if (tick) begin
            if (last_down) begin
              duty    <= '0;
              duty_wr <= (duty != '0);
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= ST_DONE;
            end else begin
              duty    <= duty - step_q;
              duty_wr <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
// Self-checking bench for pwm_ramp_sequencer: directed profile scenarios
// plus randomized runs against a behavioural profile model.
module tb_pwm_ramp_sequencer;
  import pwm_seq_pkg::*;

  localparam int PW = 10;
  localparam int TD = 4;
  localparam int HW = 16;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [PW-1:0] target, step;
  logic [HW-1:0] hold_ticks;
  logic [PW-1:0] duty;
  logic          duty_wr, busy, done;
  logic [2:0]    state_o;

  always #5 clk = ~clk;

  pwm_ramp_sequencer #(
    .PWM_BITS(PW),
    .TICK_DIV(TD),
    .HOLD_W  (HW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .target    (target),
    .step      (step),
    .hold_ticks(hold_ticks),
    .duty      (duty),
    .duty_wr   (duty_wr),
    .busy      (busy),
    .done      (done),
    .state_o   (state_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: phase name, elapsed cycles since the run began.
  int m_st = 0, m_duty = 0, m_wr = 0, m_busy = 0, m_done = 0;
  int m_el = 0, m_tgt = 0, m_stp = 1, m_hold = 0, m_hleft = 0;

  // Observation statistics for directed scenarios.
  int cyc = 0, wr_cnt = 0, peak = 0, done_cnt = 0, hold_cyc = 0;
  int t_up = -1, t_done = -1;

  task automatic model_edge();
    int prev;
    bit tk;
    prev = m_duty;
    if (rst) begin
      m_st = 0; m_duty = 0; m_wr = 0; m_busy = 0; m_done = 0;
      m_el = 0; m_hleft = 0;
      return;
    end
    m_done = 0;
    tk = (m_st != 0) && ((m_el % TD) == TD - 1);
    if (m_st != 0) m_el++;
    case (m_st)
      0: if (start && !abort) begin
        m_tgt  = int'(target);
        m_stp  = (step == 0) ? 1 : int'(step);
        m_hold = int'(hold_ticks);
        m_st   = 1;
        m_busy = 1;
        m_el   = 0;
      end
      1: if (abort) m_st = 3;
         else if (tk) begin
           if (m_duty + m_stp >= m_tgt) begin
             m_duty  = m_tgt;
             m_hleft = m_hold;
             m_st    = (m_hold != 0) ? 2 : 3;
           end else begin
             m_duty = m_duty + m_stp;
           end
         end
      2: if (abort) m_st = 3;
         else if (tk) begin
           m_hleft--;
           if (m_hleft == 0) m_st = 3;
         end
      3: if (tk) begin
           if (m_duty > m_stp) m_duty = m_duty - m_stp;
           else begin
             m_duty = 0; m_st = 4; m_busy = 0; m_done = 1;
           end
         end
      default: m_st = 0;
    endcase
    m_wr = (m_duty != prev) ? 1 : 0;
  endtask

  // One clock: advance model on the edge, compare all outputs 1ns later.
  task automatic tick_cycle();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    check_eq("duty", int'(duty), m_duty);
    check_eq("duty_wr", int'(duty_wr), m_wr);
    check_eq("busy", int'(busy), m_busy);
    check_eq("done", int'(done), m_done);
    check_eq("state_o", int'(state_o), m_st);
    if (duty_wr) wr_cnt++;
    if (int'(duty) > peak) peak = int'(duty);
    if (done) begin done_cnt++; t_done = cyc; end
    if (state_o == 3'd2) hold_cyc++;
    if (busy && t_up < 0) t_up = cyc;
  endtask

  task automatic clr_stats();
    wr_cnt = 0; peak = 0; done_cnt = 0; hold_cyc = 0; t_up = -1; t_done = -1;
  endtask

  task automatic launch(input int t, input int s, input int h);
    target = PW'(t); step = PW'(s); hold_ticks = HW'(h);
    start = 1'b1;
    tick_cycle();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int d0;
    bit hit;
    d0 = done_cnt;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick_cycle();
      if (done_cnt != d0) hit = 1'b1;
    end
    if (!hit) check_eq("done_timeout", 0, 1);
  endtask

  task automatic run_until_duty(input int val, input int budget);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < budget && !hit; i++) begin
      tick_cycle();
      if (int'(duty) == val) hit = 1'b1;
    end
    if (!hit) check_eq("duty_timeout", 0, 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    target = '0; step = '0; hold_ticks = '0;
    tick_cycle();
    tick_cycle();
    rst = 1'b0;
    check_eq("rst_duty", int'(duty), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_state", int'(state_o), 0);
    tick_cycle();

    // Full run: 4, 8, 10, hold 2 ticks, 6, 2, 0.
    clr_stats();
    launch(10, 4, 2);
    run_until_done(80);
    check_eq("s1_done_latency", t_done - t_up, 32);
    check_eq("s1_wr_count", wr_cnt, 6);
    check_eq("s1_peak", peak, 10);
    check_eq("s1_hold_cycles", hold_cyc, 2 * TD);
    check_eq("s1_busy_at_done", int'(busy), 0);
    tick_cycle();

    // Zero hold, zero step (treated as 1).
    clr_stats();
    launch(3, 0, 0);
    run_until_done(80);
    check_eq("s2_done_latency", t_done - t_up, 24);
    check_eq("s2_hold_cycles", hold_cyc, 0);
    check_eq("s2_wr_count", wr_cnt, 6);
    check_eq("s2_peak", peak, 3);
    tick_cycle();

    // Abort mid-ramp, one cycle after duty reaches 8.
    clr_stats();
    launch(10, 4, 2);
    run_until_duty(8, 40);
    tick_cycle();
    abort = 1'b1;
    tick_cycle();
    abort = 1'b0;
    check_eq("s3_state_after_abort", int'(state_o), 3);
    run_until_done(40);
    check_eq("s3_peak", peak, 8);
    check_eq("s3_done_count", done_cnt, 1);
    tick_cycle();

    // Reset during HOLD.
    clr_stats();
    launch(10, 4, 2);
    run_until_duty(10, 40);
    tick_cycle();
    rst = 1'b1;
    tick_cycle();
    rst = 1'b0;
    check_eq("s4_duty", int'(duty), 0);
    check_eq("s4_busy", int'(busy), 0);
    check_eq("s4_done", int'(done), 0);
    check_eq("s4_state", int'(state_o), 0);
    repeat (40) tick_cycle();
    check_eq("s4_no_done", done_cnt, 0);

    // Start while busy is ignored; start in DONE ignored; start in IDLE runs.
    clr_stats();
    launch(10, 4, 2);
    tick_cycle();
    tick_cycle();
    target = PW'(100);
    start  = 1'b1;
    tick_cycle();
    start  = 1'b0;
    run_until_done(80);
    check_eq("s5_peak", peak, 10);
    target = PW'(5); step = PW'(5); hold_ticks = '0;
    start  = 1'b1;
    tick_cycle();
    check_eq("s5_done_start_state", int'(state_o), 0);
    check_eq("s5_done_start_busy", int'(busy), 0);
    clr_stats();
    tick_cycle();
    start = 1'b0;
    check_eq("s5_idle_start_state", int'(state_o), 1);
    check_eq("s5_idle_start_busy", int'(busy), 1);
    run_until_done(40);
    check_eq("s5_peak2", peak, 5);
    tick_cycle();

    // target = 0: no duty change, HOLD still honoured.
    clr_stats();
    launch(0, 3, 2);
    run_until_done(60);
    check_eq("s6_wr_count", wr_cnt, 0);
    check_eq("s6_peak", peak, 0);
    check_eq("s6_hold_cycles", hold_cyc, 2 * TD);
    check_eq("s6_done_count", done_cnt, 1);
    tick_cycle();

    // Randomized runs with noisy inputs, aborts, and occasional resets.
    for (int r = 0; r < 40; r++) begin
      int budget;
      abort = 1'b0;
      launch($urandom_range(0, 60), $urandom_range(0, 20), $urandom_range(0, 3));
      budget = 0;
      while (m_st != 0 && budget < 1000) begin
        rst        = ($urandom_range(0, 199) == 0);
        abort      = ($urandom_range(0, 29) == 0);
        start      = ($urandom_range(0, 3) == 0);
        target     = PW'($urandom_range(0, 1023));
        step       = PW'($urandom_range(0, 1023));
        hold_ticks = HW'($urandom_range(0, 65535));
        tick_cycle();
        budget++;
      end
      rst = 1'b0; abort = 1'b0; start = 1'b0;
      if (budget >= 1000) check_eq("rand_timeout", 0, 1);
      tick_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
